// File: rtl/uart_tx_if.sv
// Parallel-side handshake bundle for the UART transmitter.
// Handshake: the producer may raise data_valid_in for one cycle whenever it
// observes busy_out=0; that edge is the accept edge. The payload and parity
// controls are sampled only on the accept edge. While busy_out=1, a strobe is
// dropped: it is not queued and no error is flagged.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data_in;
   logic                  data_valid_in;
   logic                  par_en_in;
   logic                  par_typ_in;
   logic                  tx_out;
   logic                  busy_out;

   // Producer side: drives the byte and request strobe, watches the line.
   modport master (
      output p_data_in,
      output data_valid_in,
      output par_en_in,
      output par_typ_in,
      input  tx_out,
      input  busy_out
   );

   // Transmitter side.
   modport slave (
      input  p_data_in,
      input  data_valid_in,
      input  par_en_in,
      input  par_typ_in,
      output tx_out,
      output busy_out
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one clk cycle per serial bit. Frame is a start bit (0),
// DATA_WIDTH data bits LSB first, an optional even/odd parity bit and one
// stop bit (1). tx_out and busy_out come straight from flops.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   uart_tx_if.slave   bus,
   output logic [2:0] state_dbg
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]            state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      bit_cnt_nxt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  parity_bit;
   logic                  tx_q;
   logic                  busy_q;

   // Parity over the held byte (odd parity flips the even result) and the
   // index of the next data bit to put on the line.
   always_comb begin
      parity_bit  = (^data_q) ^ par_typ_q;
      bit_cnt_nxt = bit_cnt + 1'b1;
   end

   // Frame sequencer. tx_q is loaded with the value that belongs to the state
   // being entered, so the line changes on the same edge as the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.data_valid_in) begin
                  data_q    <= bus.p_data_in;
                  par_en_q  <= bus.par_en_in;
                  par_typ_q <= bus.par_typ_in;
                  state     <= S_START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            S_START: begin
               state   <= S_DATA;
               bit_cnt <= '0;
               tx_q    <= data_q[0];
            end
            S_DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (par_en_q) begin
                     state <= S_PARITY;
                     tx_q  <= parity_bit;
                  end else begin
                     state <= S_STOP;
                     tx_q  <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt_nxt;
                  tx_q    <= data_q[bit_cnt_nxt];
               end
            end
            S_PARITY: begin
               state <= S_STOP;
               tx_q  <= 1'b1;
            end
            S_STOP: begin
               state  <= S_IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               bit_cnt <= '0;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Registered outputs onto the bundle, plus state for observation.
   always_comb begin
      bus.tx_out   = tx_q;
      bus.busy_out = busy_q;
      state_dbg    = state;
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Each accepted strobe pushes the expected
// per-cycle {busy_out, tx_out} pairs of the whole frame; every cycle, #1 after
// the rising edge, one pair is popped and compared. With nothing queued the
// line must be idle (tx_out=1, busy_out=0).
module tb_uart_tx;

   localparam int W = 8;

   logic       clk;
   logic       reset_n;
   logic [2:0] state_dbg;

   uart_tx_if #(.DATA_WIDTH(W)) bus ();

   uart_tx #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: entries are {busy_out, tx_out}.
   logic [1:0] exp_q[$];
   int         checks   = 0;
   int         failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected frame from a reference description of the line protocol.
   task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
      exp_q.push_back(2'b10);
      for (int i = 0; i < W; i++) exp_q.push_back({1'b1, d[i]});
      if (pe) exp_q.push_back({1'b1, (^d) ^ pt});
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b01);
   endtask

   // Advance one bit period and score the line.
   task automatic tick();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("tx_bit", bus.tx_out, e[0]);
         check("busy", bus.busy_out, e[1]);
      end else begin
         check("idle_tx", bus.tx_out, 1'b1);
         check("idle_busy", bus.busy_out, 1'b0);
      end
   endtask

   // Drive a strobe for the next edge and record the expected frame.
   task automatic strobe(input logic [W-1:0] d, input logic pe, input logic pt);
      bus.p_data_in     = d;
      bus.par_en_in     = pe;
      bus.par_typ_in    = pt;
      bus.data_valid_in = 1'b1;
      push_frame(d, pe, pt);
   endtask

   task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
      strobe(d, pe, pt);
      tick();
      bus.data_valid_in = 1'b0;
      while (exp_q.size() > 0) tick();
   endtask

   initial begin
      reset_n           = 1'b0;
      bus.p_data_in     = '0;
      bus.data_valid_in = 1'b0;
      bus.par_en_in     = 1'b0;
      bus.par_typ_in    = 1'b0;
      #12;
      check("rst_tx", bus.tx_out, 1'b1);
      check("rst_busy", bus.busy_out, 1'b0);
      check("rst_state", state_dbg, 3'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      tick();

      // Basic frames: no parity, even parity, odd parity.
      send(8'hA5, 1'b0, 1'b0);
      tick();
      send(8'h07, 1'b1, 1'b0);
      tick();
      send(8'h07, 1'b1, 1'b1);
      tick();

      // Strobes while busy are dropped; strobe at N+11 is accepted.
      strobe(8'h55, 1'b0, 1'b0);
      tick();                                   // edge N
      bus.data_valid_in = 1'b0;
      tick(); tick();                           // N+1, N+2
      bus.p_data_in = 8'hFF;
      bus.data_valid_in = 1'b1;
      tick();                                   // N+3 ignored
      bus.data_valid_in = 1'b0;
      for (int i = 4; i <= 9; i++) tick();      // N+4..N+9
      bus.data_valid_in = 1'b1;
      tick();                                   // N+10 ignored, enters idle
      check("q_empty_n10", exp_q.size(), 0);
      send(8'hFF, 1'b0, 1'b0);                  // accepted at N+11
      tick();

      // Inputs changed after accept must not affect the frame.
      strobe(8'h0F, 1'b1, 1'b0);
      tick();                                   // edge N
      bus.data_valid_in = 1'b0;
      tick();                                   // N+1
      bus.p_data_in  = 8'hF0;
      bus.par_typ_in = 1'b1;
      while (exp_q.size() > 0) tick();
      tick();

      // Reset during data bit 4.
      strobe(8'hC3, 1'b1, 1'b0);
      tick();
      bus.data_valid_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();       // through data bit 4
      reset_n = 1'b0;
      #1;
      check("midrst_tx", bus.tx_out, 1'b1);
      check("midrst_busy", bus.busy_out, 1'b0);
      check("midrst_state", state_dbg, 3'd0);
      exp_q.delete();
      tick();
      #2 reset_n = 1'b1;
      for (int i = 0; i < 12; i++) tick();      // no leftover frame
      send(8'h3C, 1'b1, 1'b1);
      tick();

      // data_valid_in held high: frames back to back.
      for (int f = 0; f < 3; f++) begin
         logic [W-1:0] d;
         d = W'($urandom_range(0, 255));
         strobe(d, f[0], 1'b0);
         while (exp_q.size() > 0) tick();
      end
      bus.data_valid_in = 1'b0;
      tick();
      tick();

      // Random frames with random gaps.
      for (int f = 0; f < 8; f++) begin
         logic [W-1:0] d;
         logic         pe;
         logic         pt;
         d  = W'($urandom_range(0, 255));
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         send(d, pe, pt);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART link. Accepts a parallel byte with a one-cycle valid strobe, serializes it LSB-first with start bit, optional even/odd parity and one stop bit, and drives the serial line. Runs on the TX baud clock: one `clk` cycle per serial bit. It is the counterpart of the oversampling receive path, which uses a prescaled edge/bit counter.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk`  in  1  TX baud clock; one bit period per cycle.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `p_data_in`  in  DATA_WIDTH  parallel payload; sampled only on the accept edge.
- `data_valid_in`  in  1  one-cycle request strobe; honoured only when `busy_out`=0.
- `par_en_in`  in  1  1 = insert parity bit; sampled on the accept edge.
- `par_typ_in`  in  1  0 = even, 1 = odd; sampled on the accept edge.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy_out`  out  1  registered; high while a frame is in flight.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out`=1, `busy_out`=0. On `data_valid_in`=1:
  - latch `p_data_in`, `par_en_in` and `par_typ_in` into holding registers;
  - go to START.
- START: `tx_out`=0 for one cycle, then go to DATA.
- DATA: `tx_out` = latched bit[i] for i = 0..DATA_WIDTH-1, LSB first, one cycle each.
  - A 3-bit counter (width ceil(log2 DATA_WIDTH)) counts bits and clears on leaving DATA.
  - After the last bit, go to PARITY if the latched `par_en` is 1, else go to STOP.
- PARITY: `tx_out` = XOR-reduce of the latched data, inverted when the latched `par_typ` is 1, for one cycle. Then go to STOP.
- STOP: `tx_out`=1 for one cycle, then go to IDLE.
- `data_valid_in` is ignored in every state except IDLE: no queuing and no error flag.
- Changes to `p_data_in` or the parity inputs after the accept edge have no effect on the current frame.
- `tx_out` and `busy_out` are flops, so they are glitch-free.

## Timing
- Reset: state=IDLE, `tx_out`=1, `busy_out`=0, holding registers=0, bit counter=0.
- Let edge N be the edge at which `data_valid_in`=1 is sampled in IDLE.
- After edge N: `tx_out`=0 (start bit) and `busy_out`=1.
- After edge N+1+i: `tx_out`=data[i], for i=0..7.
- No parity:
  - after edge N+9: stop bit;
  - after edge N+10: IDLE, `busy_out`=0.
  - Frame is 10 cycles.
- Parity:
  - after edge N+9: parity bit;
  - after edge N+10: stop bit;
  - after edge N+11: IDLE.
  - Frame is 11 cycles.
- Earliest next accept: edge N+11 without parity, N+12 with parity. The line is therefore high for at least one extra cycle between back-to-back frames.
- `busy_out` is high exactly from edge N to the edge that enters IDLE. Upstream may assert `data_valid_in` in any cycle in which it sees `busy_out`=0.
- Reset mid-frame: outputs go to their reset values immediately and asynchronously, and the frame is aborted. After release, no frame is sent until a new accept.
- `data_valid_in` held high continuously: a new frame starts on the first IDLE edge after each frame completes.

## Test plan
- 0xA5, `par_en_in`=0, single strobe -> `tx_out` sequence 0,1,0,1,0,0,1,0,1,1; then idle high. `busy_out` high for exactly 10 cycles.
- 0x07, `par_en_in`=1, `par_typ_in`=0 -> 0,1,1,1,0,0,0,0,0,1,1 (parity=1). `busy_out` high for 11 cycles.
- 0x07, `par_en_in`=1, `par_typ_in`=1 -> same sequence except the parity bit is 0.
- Accept 0x55, then pulse `data_valid_in` with 0xFF at edges N+3 and N+10 (no parity) -> only 0x55 is sent, and the line is idle high after N+10. Then a strobe at N+11 sends 0xFF starting at N+11.
- Accept 0x0F, change `p_data_in` to 0xF0 and `par_typ_in` at edge N+2 -> the transmitted bits and parity match 0x0F with the original parity settings.
- Assert `reset_n`=0 during data bit 4 -> `tx_out`=1 and `busy_out`=0 immediately. After release, the line stays high with no further frame until a new strobe, which then produces a complete correct frame.
